// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x6 membrane keypad: geometry, phase encoding and
// the keycode-to-matrix decode also used by the scanner's decoder.
package keypad_pkg;

  localparam int KP_ROWS   = 4;
  localparam int KP_COLS   = 6;
  localparam int KEYCODE_W = 5;
  localparam int KEY_MAX   = 23;

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    PRESS,
    RELEASE
  } kp_state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [2:0] col;
  } kp_pos_t;

  // Keys are numbered row-major: row = code / 6, col = code % 6.
  function automatic kp_pos_t kp_decode(input logic [KEYCODE_W-1:0] code);
    kp_pos_t pos;
    pos.row = 2'(code / KEYCODE_W'(KP_COLS));
    pos.col = 3'(code % KEYCODE_W'(KP_COLS));
    return pos;
  endfunction

  // Phase counter must hold the largest phase length; 17 bits covers 20 ms at 5 MHz.
  function automatic int kp_cnt_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m + 1);
    return (w < 17) ? 17 : w;
  endfunction

endpackage

// File: rtl/kp_cycle_timer.sv
// Loadable down-counter shared by all keypad phases; o_done marks the last
// cycle of the loaded length. It stops at 1 and never wraps.
module kp_cycle_timer #(
  parameter int W = 17
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count > W'(1)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == W'(1));

endmodule

// File: rtl/keypad_emulator.sv
// Synthesizable stand-in for the 4x6 membrane keypad: times a requested key
// press (with optional contact bounce) and answers the scanner's row strobes.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int PRESS_CYCLES   = 100000,
  parameter int RELEASE_CYCLES = 100000,
  parameter int BOUNCE_EDGES   = 0,
  parameter int BOUNCE_CYCLES  = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  output logic       key_ready,
  output logic       err,
  output logic       busy,
  input  logic [3:0] kprow,
  output logic [5:0] kpcol,
  output logic [1:0] dbg_state
);

  localparam int CNT_W  = kp_cnt_width(PRESS_CYCLES, RELEASE_CYCLES, BOUNCE_CYCLES);
  localparam int EDGE_W = (BOUNCE_EDGES > 0) ? $clog2(BOUNCE_EDGES + 1) : 1;

  localparam logic [CNT_W-1:0]  L_PRESS   = CNT_W'(PRESS_CYCLES);
  localparam logic [CNT_W-1:0]  L_RELEASE = CNT_W'(RELEASE_CYCLES);
  localparam logic [CNT_W-1:0]  L_BOUNCE  = CNT_W'(BOUNCE_CYCLES);
  localparam logic [EDGE_W-1:0] L_EDGES   = EDGE_W'(BOUNCE_EDGES);

  kp_state_t         r_state;
  logic              r_contact;
  logic [1:0]        r_row;
  logic [2:0]        r_col;
  logic [EDGE_W-1:0] r_edges;
  logic              r_ready;
  logic              r_busy;
  logic              r_err;

  kp_pos_t           w_pos;
  logic              w_code_ok;
  logic              w_accept;
  logic              w_invalid;
  logic              w_load;
  logic [CNT_W-1:0]  w_value;
  logic              w_done;

  // Handshake: a request transfers on a rising edge where key_valid and
  // key_ready are both high; key_valid while busy is dropped, never queued.
  assign w_pos     = kp_decode(key_code);
  assign w_code_ok = (key_code <= KEYCODE_W'(KEY_MAX));
  assign w_accept  = key_valid && (r_state == IDLE) && w_code_ok;
  assign w_invalid = key_valid && (r_state == IDLE) && !w_code_ok;

  always_comb begin
    w_load  = 1'b0;
    w_value = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load  = 1'b1;
          w_value = (BOUNCE_EDGES > 0) ? L_BOUNCE : L_PRESS;
        end
      end
      BOUNCE: begin
        if (w_done) begin
          w_load  = 1'b1;
          w_value = (r_edges == EDGE_W'(1)) ? L_PRESS : L_BOUNCE;
        end
      end
      PRESS: begin
        if (w_done) begin
          w_load  = 1'b1;
          w_value = L_RELEASE;
        end
      end
      default: begin
        w_load  = 1'b0;
        w_value = '0;
      end
    endcase
  end

  kp_cycle_timer #(
    .W(CNT_W)
  ) u_timer (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_load  (w_load),
    .i_value (w_value),
    .o_done  (w_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_contact <= 1'b0;
      r_row     <= '0;
      r_col     <= '0;
      r_edges   <= '0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_invalid;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_row     <= w_pos.row;
            r_col     <= w_pos.col;
            r_contact <= 1'b1;
            r_edges   <= L_EDGES;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= (BOUNCE_EDGES > 0) ? BOUNCE : PRESS;
          end
        end
        BOUNCE: begin
          // An even toggle count leaves the contact closed for the stable press.
          if (w_done) begin
            r_contact <= ~r_contact;
            r_edges   <= r_edges - EDGE_W'(1);
            if (r_edges == EDGE_W'(1)) begin
              r_state <= PRESS;
            end
          end
        end
        PRESS: begin
          if (w_done) begin
            r_contact <= 1'b0;
            r_state   <= RELEASE;
          end
        end
        RELEASE: begin
          if (w_done) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Passive switch: the latched column follows the latched row strobe directly.
  always_comb begin
    kpcol = '1;
    if (r_contact && !kprow[r_row]) begin
      kpcol[r_col] = 1'b0;
    end
  end

  assign key_ready = r_ready;
  assign busy      = r_busy;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: vector table, bounce/back-to-back/reset
// sequences and randomized traffic against a timeline model of each press.
module tb_keypad_emulator;

  localparam int PC   = 20;
  localparam int RC   = 10;
  localparam int BE_B = 4;
  localparam int BC_B = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid, key_valid_b;
  logic [4:0] key_code, key_code_b;
  logic [3:0] kprow, kprow_b;
  logic       key_ready, key_ready_b;
  logic       err, err_b;
  logic       busy, busy_b;
  logic [5:0] kpcol, kpcol_b;
  logic [1:0] dbg_state, dbg_state_b;

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  keypad_emulator #(
    .PRESS_CYCLES(PC), .RELEASE_CYCLES(RC), .BOUNCE_EDGES(0), .BOUNCE_CYCLES(1)
  ) dut (
    .clk(clk), .reset(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .err(err), .busy(busy), .kprow(kprow),
    .kpcol(kpcol), .dbg_state(dbg_state)
  );

  keypad_emulator #(
    .PRESS_CYCLES(PC), .RELEASE_CYCLES(RC), .BOUNCE_EDGES(BE_B), .BOUNCE_CYCLES(BC_B)
  ) dut_b (
    .clk(clk), .reset(rst), .key_valid(key_valid_b), .key_code(key_code_b),
    .key_ready(key_ready_b), .err(err_b), .busy(busy_b), .kprow(kprow_b),
    .kpcol(kpcol_b), .dbg_state(dbg_state_b)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] exp_q[$];

  // Timeline model: edges counted since start; a press accepted at edge m_acc keeps
  // the contact closed after edges m_acc..m_acc+PC-1, ready again after m_rdy_edge.
  int cyc = 0;
  bit m_have = 1'b0;
  int m_acc = 0;
  int m_rdy_edge = 0;
  bit m_err = 1'b0;
  int m_row = 0;
  int m_col = 0;

  typedef struct {
    logic [4:0] code;
    logic [3:0] row_drv;
    logic [5:0] exp_col;
    logic       exp_err;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit m_contact(input int e);
    int t;
    if (!m_have) return 1'b0;
    t = e - m_acc;
    return (t >= 0) && (t < PC);
  endfunction

  function automatic logic [5:0] m_kpcol();
    logic [5:0] e;
    e = '1;
    if (m_contact(cyc) && kprow[m_row] == 1'b0) e[m_col] = 1'b0;
    return e;
  endfunction

  task automatic model_edge();
    bit pr;
    pr = (cyc >= m_rdy_edge);
    cyc++;
    m_err = 1'b0;
    if (key_valid && pr) begin
      if (int'(key_code) <= 23) begin
        m_have     = 1'b1;
        m_acc      = cyc;
        m_rdy_edge = cyc + PC + RC;
        m_row      = int'(key_code) / 6;
        m_col      = int'(key_code) % 6;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_have     = 1'b0;
    m_rdy_edge = cyc;
    m_err      = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("kpcol", kpcol, m_kpcol());
    check("key_ready", key_ready, cyc >= m_rdy_edge);
    check("busy", busy, !(cyc >= m_rdy_edge));
    check("err", err, m_err);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  initial begin
    int kb;
    int waited;
    logic [11:0] pat;

    rst = 1'b1;
    key_valid = 1'b0; key_code = '0; kprow = 4'hF;
    key_valid_b = 1'b0; key_code_b = '0; kprow_b = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", key_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_kpcol", kpcol, 6'h3F);
    check("rst_state", dbg_state, 0);
    check("rst_ready_b", key_ready_b, 1);
    check("rst_kpcol_b", kpcol_b, 6'h3F);
    rst = 1'b0;
    model_reset();
    tick();

    // ---------------- vector table ----------------
    vecs[0] = '{5'd7,  4'b1101, 6'b111101, 1'b0, 1'b1};
    vecs[1] = '{5'd7,  4'b1110, 6'b111111, 1'b0, 1'b1};
    vecs[2] = '{5'd25, 4'b1101, 6'b111111, 1'b1, 1'b0};
    vecs[3] = '{5'd0,  4'b1110, 6'b111110, 1'b0, 1'b1};
    vecs[4] = '{5'd23, 4'b0111, 6'b011111, 1'b0, 1'b1};
    vecs[5] = '{5'd12, 4'b1011, 6'b111110, 1'b0, 1'b1};
    vecs[6] = '{5'd17, 4'b0000, 6'b011111, 1'b0, 1'b1};
    vecs[7] = '{5'd10, 4'b1111, 6'b111111, 1'b0, 1'b1};

    for (int i = 0; i < 8; i++) begin
      key_valid = 1'b1;
      key_code  = vecs[i].code;
      kprow     = vecs[i].row_drv;
      tick();
      key_valid = 1'b0;
      check("vec_kpcol", kpcol, vecs[i].exp_col);
      check("vec_err", err, vecs[i].exp_err);
      check("vec_busy", busy, vecs[i].exp_busy);
      repeat (PC - 1) tick();
      check("vec_press_end", kpcol, vecs[i].exp_col);
      repeat (RC) tick();
      check("vec_rdy_late", key_ready, !vecs[i].exp_busy);
      tick();
      check("vec_rdy_back", key_ready, 1);
    end

    // ---------------- bounce sequence on dut_b ----------------
    pat = 12'b000111000111;
    for (int i = 0; i < 12; i++) exp_q.push_back({5'b11111, pat[11 - i]});
    for (int i = 0; i < PC; i++) exp_q.push_back(6'b111110);
    for (int i = 0; i < RC; i++) exp_q.push_back(6'b111111);
    key_valid_b = 1'b1;
    key_code_b  = 5'd0;
    kprow_b     = 4'b1110;
    tick();
    key_valid_b = 1'b0;
    for (int i = 0; i < BE_B * BC_B + PC + RC; i++) begin
      check("bounce_kpcol", kpcol_b, exp_q.pop_front());
      check("bounce_ready", key_ready_b, 0);
      check("bounce_busy", busy_b, 1);
      if (i < BE_B * BC_B + PC + RC - 1) tick();
    end
    tick();
    check("bounce_ready_back", key_ready_b, 1);
    check("bounce_idle_kpcol", kpcol_b, 6'h3F);

    // ---------------- back-to-back 23 then 5 ----------------
    kprow     = 4'b0110;
    key_valid = 1'b1;
    key_code  = 5'd23;
    tick();
    kb = cyc;
    key_code = 5'd5;
    waited = 0;
    while (!key_ready && waited < 100) begin
      tick();
      waited++;
    end
    check("b2b_ready_edge", cyc - kb, PC + RC);
    tick();
    key_valid = 1'b0;
    check("b2b_second_busy", busy, 1);
    check("b2b_second_col", kpcol, 6'b011111);
    repeat (PC + RC) tick();

    // ---------------- reset mid-press ----------------
    kprow     = 4'b1101;
    key_valid = 1'b1;
    key_code  = 5'd7;
    tick();
    key_valid = 1'b0;
    repeat (7) tick();
    check("pre_rst_kpcol", kpcol, 6'b111101);
    rst = 1'b1;
    #1;
    check("rst_async_kpcol", kpcol, 6'h3F);
    check("rst_async_ready", key_ready, 1);
    check("rst_async_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("post_rst_ready", key_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_state", dbg_state, 0);
    key_valid = 1'b1;
    key_code  = 5'd0;
    kprow     = 4'b1110;
    tick();
    key_valid = 1'b0;
    check("post_rst_accept_col", kpcol, 6'b111110);
    check("post_rst_accept_busy", busy, 1);
    repeat (PC + RC) tick();
    check("post_rst_done", key_ready, 1);

    // ---------------- randomized traffic ----------------
    repeat (600) begin
      key_valid = ($urandom_range(0, 3) == 0);
      key_code  = 5'($urandom_range(0, 31));
      kprow     = 4'($urandom_range(0, 15));
      tick();
    end
    key_valid = 1'b0;
    repeat (PC + RC + 2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
